tdm_burst_scheduler: RTL and testbench

Time-division scheduler that shares one output data channel between `NUM_REQ` burst sources on a fixed, repeating frame. Each requester owns one slot per frame. A slot is a fixed data window of `BURST_LEN` cycles followed by `GUARD_CYCLES` idle cycles. The block sits between the per-source burst generators and the shared channel, and it owns all slot and frame sequencing.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_slot_counter.sv | 29 ++
 rtl/tdm_burst_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tdm_burst_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the TDM burst scheduler.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        GUARD = 2'd2
    } tdm_state_e;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_BURST_LEN = 16;

    localparam int unsigned SLOT_W = $clog2(DEF_NUM_REQ);
    localparam int unsigned WIN_W  = $clog2(DEF_BURST_LEN);

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping up-counter 0..FINAL_COUNT with a wrap pulse on the terminal increment.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned W           = WIN_W,
    parameter int unsigned FINAL_COUNT = DEF_BURST_LEN - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic at_final;

    assign at_final = (count == W'(FINAL_COUNT));
    assign wrap     = inc && at_final;

    // Count on inc, return to zero after the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= at_final ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/tdm_burst_scheduler.sv
// Fixed-frame TDM scheduler: one data window plus guard per requester per frame.
module tdm_burst_scheduler
    import tdm_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
    parameter int unsigned GUARD_CYCLES = 2,
    localparam int unsigned SLOT_BITS   = cnt_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [SLOT_BITS-1:0]      out_chan,
    output logic                      out_last,
    output logic                      frame_start,
    output logic [NUM_REQ-1:0]        slot_miss
);

    localparam int unsigned WIN_BITS   = cnt_w(BURST_LEN);
    localparam int unsigned GUARD_BITS = cnt_w(GUARD_CYCLES);

    tdm_state_e           state_q;
    tdm_state_e           state_d;
    logic [SLOT_BITS-1:0] slot_q;
    logic [WIN_BITS-1:0]  win_q;
    logic                 slot_inc;
    logic                 slot_wrap;
    logic                 win_inc;
    logic                 win_wrap;
    logic                 guard_inc;
    logic                 guard_wrap;
    logic                 slot_last;
    logic                 in_data;
    logic                 hs;
    logic                 beat_q;
    logic                 unused_slot_wrap;
    logic [DATA_W-1:0]    words [NUM_REQ];

    assign in_data   = (state_q == DATA);
    assign win_inc   = in_data;
    assign guard_inc = (state_q == GUARD);
    assign slot_last = (slot_q == SLOT_BITS'(NUM_REQ - 1));
    assign hs        = in_data && req_valid[slot_q] && out_ready;

    // Slot wrap is implied by slot_last at the boundary; the pulse itself is not needed.
    assign unused_slot_wrap = slot_wrap;

    tdm_slot_counter #(
        .W           (SLOT_BITS),
        .FINAL_COUNT (NUM_REQ - 1)
    ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (slot_inc),
        .count (slot_q),
        .wrap  (slot_wrap)
    );

    tdm_slot_counter #(
        .W           (WIN_BITS),
        .FINAL_COUNT (BURST_LEN - 1)
    ) u_win (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (win_inc),
        .count (win_q),
        .wrap  (win_wrap)
    );

    if (GUARD_CYCLES > 0) begin : g_guard
        logic [GUARD_BITS-1:0] gcnt;
        logic                  unused_gcnt;

        tdm_slot_counter #(
            .W           (GUARD_BITS),
            .FINAL_COUNT (GUARD_CYCLES - 1)
        ) u_gcnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (guard_inc),
            .count (gcnt),
            .wrap  (guard_wrap)
        );

        // Only the terminal pulse drives sequencing.
        assign unused_gcnt = ^gcnt;
    end else begin : g_no_guard
        assign guard_wrap = 1'b0;
    end

    // Unpack the flat requester data bus into per-requester words.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_W +: DATA_W];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot advance; en only matters at the frame's final boundary.
    always_comb begin
        state_d  = state_q;
        slot_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (win_wrap) begin
                    if (GUARD_CYCLES == 0) begin
                        slot_inc = 1'b1;
                        state_d  = (slot_last && !en) ? IDLE : DATA;
                    end else begin
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                if (guard_wrap) begin
                    slot_inc = 1'b1;
                    state_d  = (slot_last && !en) ? IDLE : DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Zero-latency mux between the slot owner and the shared channel.
    always_comb begin
        out_valid = 1'b0;
        req_ready = '0;
        out_data  = words[slot_q];
        if (in_data) begin
            out_valid         = req_valid[slot_q];
            req_ready[slot_q] = out_ready;
        end
    end

    assign out_chan    = slot_q;
    assign out_last    = in_data && (win_q == WIN_BITS'(BURST_LEN - 1));
    assign frame_start = in_data && (slot_q == '0) && (win_q == '0);

    // Per-window beat flag, cleared as each window closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= 1'b0;
        end else if (in_data) begin
            beat_q <= win_wrap ? 1'b0 : (beat_q | hs);
        end
    end

    // Flag a window that closed without a single completed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_miss <= '0;
        end else begin
            slot_miss <= '0;
            if (win_wrap && !(beat_q || hs)) begin
                slot_miss[slot_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_burst_scheduler.sv
// Bench for tdm_burst_scheduler: default instance plus a back-to-back (B=2, G=0) instance.
module tb_tdm_burst_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int B1   = 16;
    localparam int G1   = 2;
    localparam int B2   = 2;
    localparam int G2   = 0;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic                 out_ready;

    logic [NREQ-1:0] d1_req_ready, d2_req_ready;
    logic            d1_out_valid, d2_out_valid;
    logic [DW-1:0]   d1_out_data, d2_out_data;
    logic [1:0]      d1_out_chan, d2_out_chan;
    logic            d1_out_last, d2_out_last;
    logic            d1_frame_start, d2_frame_start;
    logic [NREQ-1:0] d1_slot_miss, d2_slot_miss;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_burst_scheduler #(.NUM_REQ(NREQ), .DATA_W(DW), .BURST_LEN(B1), .GUARD_CYCLES(G1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(d1_req_ready), .out_valid(d1_out_valid), .out_data(d1_out_data),
        .out_ready(out_ready), .out_chan(d1_out_chan), .out_last(d1_out_last),
        .frame_start(d1_frame_start), .slot_miss(d1_slot_miss)
    );

    tdm_burst_scheduler #(.NUM_REQ(NREQ), .DATA_W(DW), .BURST_LEN(B2), .GUARD_CYCLES(G2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(d2_req_ready), .out_valid(d2_out_valid), .out_data(d2_out_data),
        .out_ready(out_ready), .out_chan(d2_out_chan), .out_last(d2_out_last),
        .frame_start(d2_frame_start), .slot_miss(d2_slot_miss)
    );

    // Reference model: position within a frame, counted in plain cycles.
    typedef struct {
        bit          run;
        int          t;
        int          beats;
        logic [3:0]  miss;
    } ms_t;

    typedef struct {
        logic [3:0] rdy;
        logic       v;
        logic [7:0] d;
        logic [1:0] ch;
        logic       last;
        logic       fs;
        logic [3:0] miss;
    } eo_t;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic       ready;
        logic [1:0] ch;
        logic       last;
        logic       fs;
        logic       v;
        logic [3:0] miss;
    } vec_t;

    ms_t s1, s2;
    logic [1:0] smp1_ch, smp2_ch;
    logic       smp1_hs, smp1_last, smp1_fs, smp1_v;
    logic       smp2_last, smp2_fs, smp2_v;
    logic [3:0] smp1_miss, smp2_miss;

    function automatic ms_t m_reset();
        ms_t r;
        r.run = 1'b0; r.t = 0; r.beats = 0; r.miss = 4'h0;
        return r;
    endfunction

    function automatic eo_t m_out(input ms_t s, input int b, input int g);
        eo_t e;
        int  sl, pos;
        bit  ind;
        sl  = s.run ? s.t / (b + g) : 0;
        pos = s.run ? s.t % (b + g) : 0;
        ind = s.run && (pos < b);
        e.ch   = 2'(sl);
        e.d    = req_data[sl*DW +: DW];
        e.v    = ind && req_valid[sl];
        e.rdy  = (ind && out_ready) ? 4'(1 << sl) : 4'h0;
        e.last = ind && (pos == b - 1);
        e.fs   = ind && (s.t == 0);
        e.miss = s.miss;
        if (!rst_n) begin
            e.ch = 2'd0; e.d = req_data[DW-1:0]; e.v = 1'b0; e.rdy = 4'h0;
            e.last = 1'b0; e.fs = 1'b0; e.miss = 4'h0;
        end
        return e;
    endfunction

    function automatic ms_t m_next(input ms_t s, input int b, input int g);
        ms_t n;
        int  sl, pos, nb;
        bit  ind, hs;
        if (!rst_n) return m_reset();
        n      = s;
        n.miss = 4'h0;
        if (!s.run) begin
            n.beats = 0;
            if (en) begin
                n.run = 1'b1;
                n.t   = 0;
            end
        end else begin
            sl  = s.t / (b + g);
            pos = s.t % (b + g);
            ind = (pos < b);
            hs  = ind && req_valid[sl] && out_ready;
            if (ind) begin
                nb = s.beats + (hs ? 1 : 0);
                if (pos == b - 1) begin
                    n.miss  = (nb == 0) ? 4'(1 << sl) : 4'h0;
                    n.beats = 0;
                end else begin
                    n.beats = nb;
                end
            end
            if (s.t == NREQ * (b + g) - 1) begin
                n.t   = 0;
                n.run = en;
            end else begin
                n.t = s.t + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare both instances against the model at negedge, then advance.
    task automatic step();
        eo_t e1, e2;
        @(negedge clk);
        e1 = m_out(s1, B1, G1);
        e2 = m_out(s2, B2, G2);
        chk("d1 out_chan",    32'(d1_out_chan),    32'(e1.ch));
        chk("d1 out_valid",   32'(d1_out_valid),   32'(e1.v));
        chk("d1 req_ready",   32'(d1_req_ready),   32'(e1.rdy));
        chk("d1 out_data",    32'(d1_out_data),    32'(e1.d));
        chk("d1 out_last",    32'(d1_out_last),    32'(e1.last));
        chk("d1 frame_start", 32'(d1_frame_start), 32'(e1.fs));
        chk("d1 slot_miss",   32'(d1_slot_miss),   32'(e1.miss));
        chk("d2 out_chan",    32'(d2_out_chan),    32'(e2.ch));
        chk("d2 out_valid",   32'(d2_out_valid),   32'(e2.v));
        chk("d2 req_ready",   32'(d2_req_ready),   32'(e2.rdy));
        chk("d2 out_data",    32'(d2_out_data),    32'(e2.d));
        chk("d2 out_last",    32'(d2_out_last),    32'(e2.last));
        chk("d2 frame_start", 32'(d2_frame_start), 32'(e2.fs));
        chk("d2 slot_miss",   32'(d2_slot_miss),   32'(e2.miss));
        smp1_ch = d1_out_chan; smp1_hs = d1_out_valid && out_ready; smp1_v = d1_out_valid;
        smp1_last = d1_out_last; smp1_fs = d1_frame_start; smp1_miss = d1_slot_miss;
        smp2_ch = d2_out_chan; smp2_v = d2_out_valid; smp2_last = d2_out_last;
        smp2_fs = d2_frame_start; smp2_miss = d2_slot_miss;
        s1 = m_next(s1, B1, G1);
        s2 = m_next(s2, B2, G2);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    vec_t tbl [10];
    int   beats [4];
    int   lasts, fs_cnt, first_last, second_last, first_fs, second_fs;
    int   miss_cnt, valid_after;
    logic [3:0] miss_or, miss_val, dead;

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = 4'h0; out_ready = 1'b0;
        req_data = 32'hD4C3_B2A1;
        s1 = m_reset(); s2 = m_reset();

        // Back-to-back windows on the B=2, G=0 instance.
        tbl[0] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'h0};
        tbl[2] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[3] = '{1'b1, 4'hD, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[4] = '{1'b1, 4'hD, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[5] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 4'h2};
        tbl[6] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[7] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[8] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[9] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'h0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en; req_valid = tbl[i].valid; out_ready = tbl[i].ready;
            step();
            chk("tbl out_chan",    32'(smp2_ch),   32'(tbl[i].ch));
            chk("tbl out_last",    32'(smp2_last), 32'(tbl[i].last));
            chk("tbl frame_start", 32'(smp2_fs),   32'(tbl[i].fs));
            chk("tbl out_valid",   32'(smp2_v),    32'(tbl[i].v));
            chk("tbl slot_miss",   32'(smp2_miss), 32'(tbl[i].miss));
        end

        // Two full frames, everything ready.
        do_reset();
        en = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        lasts = 0; fs_cnt = 0; first_last = -1; second_last = -1;
        first_fs = -1; second_fs = -1; miss_or = 4'h0;
        for (int k = 0; k < 145; k++) begin
            step();
            if (smp1_hs) beats[smp1_ch]++;
            if (smp1_last) begin
                if (lasts == 0) first_last = k;
                if (lasts == 1) second_last = k;
                lasts++;
            end
            if (smp1_fs) begin
                if (fs_cnt == 0) first_fs = k;
                if (fs_cnt == 1) second_fs = k;
                fs_cnt++;
            end
            miss_or = miss_or | smp1_miss;
        end
        for (int i = 0; i < 4; i++) chk("full beats per slot", 32'(beats[i]), 32'd32);
        chk("full out_last count",   32'(lasts), 32'd8);
        chk("full out_last spacing", 32'(second_last - first_last), 32'd18);
        chk("full first data cycle", 32'(first_fs), 32'd1);
        chk("full frame_start spacing", 32'(second_fs - first_fs), 32'd72);
        chk("full slot_miss", 32'(miss_or), 32'd0);

        // Requester 2 silent for one frame.
        req_valid = 4'hB; miss_cnt = 0; miss_val = 4'h0;
        for (int k = 0; k < 72; k++) begin
            step();
            if (smp1_miss != 4'h0) begin
                miss_cnt++;
                miss_val = smp1_miss;
            end
        end
        req_valid = 4'hF;
        chk("miss pulse count", 32'(miss_cnt), 32'd1);
        chk("miss pulse value", 32'(miss_val), 32'h4);

        // out_ready toggling every cycle.
        for (int i = 0; i < 4; i++) beats[i] = 0;
        for (int k = 0; k < 72; k++) begin
            out_ready = (k % 2 == 0);
            step();
            if (smp1_hs) beats[smp1_ch]++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) chk("toggle beats per slot", 32'(beats[i]), 32'd8);

        // en dropped during slot 1: frame completes, then idle.
        for (int i = 0; i < 4; i++) beats[i] = 0;
        for (int k = 0; k < 72; k++) begin
            if (k == 25) en = 1'b0;
            step();
            if (smp1_hs) beats[smp1_ch]++;
        end
        chk("en drop slot2 beats", 32'(beats[2]), 32'd16);
        chk("en drop slot3 beats", 32'(beats[3]), 32'd16);
        valid_after = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (smp1_v) valid_after++;
        end
        chk("idle out_valid count", 32'(valid_after), 32'd0);

        // Reset mid-window in slot 2.
        en = 1'b1;
        for (int k = 0; k < 42; k++) step();
        chk("pre-reset slot", 32'(d1_out_chan), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid",   32'(d1_out_valid),   32'd0);
        chk("rst req_ready",   32'(d1_req_ready),   32'd0);
        chk("rst out_last",    32'(d1_out_last),    32'd0);
        chk("rst frame_start", 32'(d1_frame_start), 32'd0);
        chk("rst slot_miss",   32'(d1_slot_miss),   32'd0);
        chk("rst out_chan",    32'(d1_out_chan),    32'd0);
        chk("rst out_data",    32'(d1_out_data),    32'h0000_00A1);
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset idle fs", 32'(smp1_fs), 32'd0);
        step();
        chk("post-reset frame_start", 32'(smp1_fs), 32'd1);
        chk("post-reset out_chan",    32'(smp1_ch), 32'd0);

        // Randomized traffic checked against the model every cycle.
        dead = 4'h0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 100 == 0) dead = 4'($urandom) & 4'($urandom);
            rst_n     = ($urandom_range(0, 999) != 0);
            en        = ($urandom_range(0, 19) != 0);
            req_valid = 4'($urandom) & ~dead;
            out_ready = ($urandom_range(0, 3) != 0);
            req_data  = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
